// File: rtl/bullet_tracer.sv
// Projectile tracker: spawns a slot per shot, steps live slots each frame, scans slot/zombie pairs for hits.
// Latency: a frame edge becomes SPAWN two cycles later; each hit strobes one cycle after its pair is scanned.
// Backpressure: none; a shot with no free slot is dropped and Shot_Dropped pulses, and frame edges are ignored while busy.
//
// Ports:
//   Clk, Reset (sync, active-high), Start (low = reset), frame_clk (V-SYNC level)
//   If_Shot/Bullet_Damage/Facing/Player_X/Player_Y : per-player shot request and spawn attributes
//   RedBox_X/RedBox_Y/RedBox_Exist                 : zombie centres and valid mask
//   Tracer_X/Tracer_Y/Tracer_Live                  : per-slot projectile state for the renderer
//   Hit_Strobe/Hit_Zombie/Hit_Damage               : one-cycle hit report to zombie HP logic
//   Shot_Dropped                                   : one-cycle pulse per player when a shot found no slot
//   Busy                                           : high whenever the frame sequence is running
module bullet_tracer #(
  parameter int         N_SLOT = 4,
  parameter logic [9:0] SPEED  = 10'd8,
  parameter logic [9:0] HIT_R  = 10'd12,
  parameter logic [9:0] H_MAX  = 10'd640,
  parameter logic [9:0] V_MAX  = 10'd480
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic                     Start,
  input  logic [1:0]               If_Shot,
  input  logic [1:0][6:0]          Bullet_Damage,
  input  logic [1:0][1:0]          Facing,
  input  logic [1:0][9:0]          Player_X,
  input  logic [1:0][9:0]          Player_Y,
  input  logic [9:0][9:0]          RedBox_X,
  input  logic [9:0][9:0]          RedBox_Y,
  input  logic [9:0]               RedBox_Exist,
  output logic [2*N_SLOT-1:0][9:0] Tracer_X,
  output logic [2*N_SLOT-1:0][9:0] Tracer_Y,
  output logic [2*N_SLOT-1:0]      Tracer_Live,
  output logic                     Hit_Strobe,
  output logic [3:0]               Hit_Zombie,
  output logic [6:0]               Hit_Damage,
  output logic [1:0]               Shot_Dropped,
  output logic                     Busy
);

  localparam int NS = 2 * N_SLOT;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, SPAWN, MOVE, SCAN} state_t;

  state_t               state_q, state_d;
  logic                 frame_prev_q, frame_prev_d;
  logic                 frame_edge_q, frame_edge_d;
  logic [1:0]           shot_prev_q, shot_prev_d;
  logic [1:0]           pend_q, pend_d;
  logic [NS-1:0]        live_q, live_d;
  logic [NS-1:0]        fresh_q, fresh_d;   // spawned this frame, skipped by MOVE
  logic [NS-1:0][9:0]   x_q, x_d;
  logic [NS-1:0][9:0]   y_q, y_d;
  logic [NS-1:0][1:0]   dir_q, dir_d;
  logic [NS-1:0][6:0]   dmg_q, dmg_d;
  logic [SW-1:0]        s_q, s_d;
  logic [3:0]           z_q, z_d;
  logic                 hit_strobe_q, hit_strobe_d;
  logic [3:0]           hit_zombie_q, hit_zombie_d;
  logic [6:0]           hit_damage_q, hit_damage_d;
  logic [1:0]           drop_q, drop_d;

  logic                 rst;
  logic                 spawn_found;
  logic [9:0]           dist_x, dist_y;
  logic                 pair_hit;

  // Dropping Start parks the block exactly as a reset does.
  assign rst = Reset | ~Start;

  // Compare first so the subtraction can never wrap.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  assign dist_x   = abs_diff(x_q[s_q], RedBox_X[z_q]);
  assign dist_y   = abs_diff(y_q[s_q], RedBox_Y[z_q]);
  assign pair_hit = live_q[s_q] && RedBox_Exist[z_q] && (dist_x < HIT_R) && (dist_y < HIT_R);

  always_comb begin
    state_d      = state_q;
    frame_prev_d = frame_clk;
    frame_edge_d = frame_clk & ~frame_prev_q;
    shot_prev_d  = If_Shot;
    pend_d       = pend_q;
    live_d       = live_q;
    fresh_d      = fresh_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    dmg_d        = dmg_q;
    s_d          = s_q;
    z_d          = z_q;
    hit_strobe_d = 1'b0;
    hit_zombie_d = 4'd0;
    hit_damage_d = 7'd0;
    drop_d       = 2'b00;
    spawn_found  = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_edge_q) state_d = SPAWN;
      end

      SPAWN: begin
        for (int p = 0; p < 2; p++) begin
          spawn_found = 1'b0;
          if (pend_q[p]) begin
            for (int k = 0; k < N_SLOT; k++) begin
              if (!spawn_found && !live_q[p*N_SLOT+k]) begin
                spawn_found            = 1'b1;
                live_d[p*N_SLOT+k]  = 1'b1;
                fresh_d[p*N_SLOT+k] = 1'b1;
                x_d[p*N_SLOT+k]     = Player_X[p];
                y_d[p*N_SLOT+k]     = Player_Y[p];
                dir_d[p*N_SLOT+k]   = Facing[p];
                dmg_d[p*N_SLOT+k]   = Bullet_Damage[p];
              end
            end
            if (!spawn_found) drop_d[p] = 1'b1;
          end
        end
        pend_d  = 2'b00;
        state_d = MOVE;
      end

      MOVE: begin
        // A step that would leave the playfield frees the slot and leaves its position as-is.
        for (int i = 0; i < NS; i++) begin
          if (live_q[i] && !fresh_q[i]) begin
            case (dir_q[i])
              2'b00: if (y_q[i] < SPEED) live_d[i] = 1'b0;
                     else y_d[i] = y_q[i] - SPEED;
              2'b01: if (({1'b0, y_q[i]} + {1'b0, SPEED}) >= {1'b0, V_MAX}) live_d[i] = 1'b0;
                     else y_d[i] = y_q[i] + SPEED;
              2'b10: if (x_q[i] < SPEED) live_d[i] = 1'b0;
                     else x_d[i] = x_q[i] - SPEED;
              default: if (({1'b0, x_q[i]} + {1'b0, SPEED}) >= {1'b0, H_MAX}) live_d[i] = 1'b0;
                       else x_d[i] = x_q[i] + SPEED;
            endcase
          end
        end
        fresh_d = '0;
        s_d     = '0;
        z_d     = 4'd0;
        state_d = SCAN;
      end

      SCAN: begin
        // Killing the slot here makes the remaining zombies for this slot miss.
        if (pair_hit) begin
          hit_strobe_d = 1'b1;
          hit_zombie_d = z_q;
          hit_damage_d = dmg_q[s_q];
          live_d[s_q]  = 1'b0;
        end
        if (z_q == 4'd9) begin
          z_d = 4'd0;
          if (s_q == SW'(NS - 1)) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end else begin
          z_d = z_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Shot capture runs in every state; an edge in the SPAWN cycle survives the clear.
    pend_d = pend_d | (If_Shot & ~shot_prev_q);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_prev_q <= 1'b0;
      frame_edge_q <= 1'b0;
      shot_prev_q  <= 2'b00;
      pend_q       <= 2'b00;
      live_q       <= '0;
      fresh_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      dir_q        <= '0;
      dmg_q        <= '0;
      s_q          <= '0;
      z_q          <= 4'd0;
      hit_strobe_q <= 1'b0;
      hit_zombie_q <= 4'd0;
      hit_damage_q <= 7'd0;
      drop_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_prev_d;
      frame_edge_q <= frame_edge_d;
      shot_prev_q  <= shot_prev_d;
      pend_q       <= pend_d;
      live_q       <= live_d;
      fresh_q      <= fresh_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      dmg_q        <= dmg_d;
      s_q          <= s_d;
      z_q          <= z_d;
      hit_strobe_q <= hit_strobe_d;
      hit_zombie_q <= hit_zombie_d;
      hit_damage_q <= hit_damage_d;
      drop_q       <= drop_d;
    end
  end

  assign Tracer_X     = x_q;
  assign Tracer_Y     = y_q;
  assign Tracer_Live  = live_q;
  assign Hit_Strobe   = hit_strobe_q;
  assign Hit_Zombie   = hit_zombie_q;
  assign Hit_Damage   = hit_damage_q;
  assign Shot_Dropped = drop_q;
  assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bullet_tracer.sv
module tb_bullet_tracer;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             frame_clk;
  logic             Start;
  logic [1:0]       If_Shot;
  logic [1:0][6:0]  Bullet_Damage;
  logic [1:0][1:0]  Facing;
  logic [1:0][9:0]  Player_X, Player_Y;
  logic [9:0][9:0]  RedBox_X, RedBox_Y;
  logic [9:0]       RedBox_Exist;
  logic [7:0][9:0]  Tracer_X, Tracer_Y;
  logic [7:0]       Tracer_Live;
  logic             Hit_Strobe;
  logic [3:0]       Hit_Zombie;
  logic [6:0]       Hit_Damage;
  logic [1:0]       Shot_Dropped;
  logic             Busy;

  int checks = 0;
  int errors = 0;

  // kind 0: hit (a = zombie, b = damage); kind 1: drop (a = player)
  typedef struct { int kind; int a; int b; } ev_t;
  ev_t exp_q[$];

  bullet_tracer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start),
    .If_Shot(If_Shot), .Bullet_Damage(Bullet_Damage), .Facing(Facing),
    .Player_X(Player_X), .Player_Y(Player_Y),
    .RedBox_X(RedBox_X), .RedBox_Y(RedBox_Y), .RedBox_Exist(RedBox_Exist),
    .Tracer_X(Tracer_X), .Tracer_Y(Tracer_Y), .Tracer_Live(Tracer_Live),
    .Hit_Strobe(Hit_Strobe), .Hit_Zombie(Hit_Zombie), .Hit_Damage(Hit_Damage),
    .Shot_Dropped(Shot_Dropped), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a hit or drop pulse.
  always @(negedge Clk) begin
    if (Hit_Strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL hit_unexpected actual zombie=%0d dmg=%0d expected none", Hit_Zombie, Hit_Damage);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.kind != 0 || e.a != int'(Hit_Zombie) || e.b != int'(Hit_Damage)) begin
          errors++;
          $display("FAIL hit_event actual hit zombie=%0d dmg=%0d expected kind=%0d a=%0d b=%0d",
                   Hit_Zombie, Hit_Damage, e.kind, e.a, e.b);
        end
      end
    end else begin
      checks++;
      if (Hit_Zombie != 4'd0 || Hit_Damage != 7'd0) begin
        errors++;
        $display("FAIL hit_idle_zero actual zombie=%0d dmg=%0d expected 0 0", Hit_Zombie, Hit_Damage);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (Shot_Dropped[p]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL drop_unexpected actual player=%0d expected none", p);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.kind != 1 || e.a != p) begin
            errors++;
            $display("FAIL drop_event actual drop player=%0d expected kind=%0d a=%0d", p, e.kind, e.a);
          end
        end
      end
    end
  end

  task automatic push_hit(input int z, input int d);
    ev_t e;
    e.kind = 0; e.a = z; e.b = d;
    exp_q.push_back(e);
  endtask

  task automatic push_drop(input int p);
    ev_t e;
    e.kind = 1; e.a = p; e.b = 0;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic shot(input logic [1:0] mask);
    If_Shot = mask;
    repeat (2) @(posedge Clk);
    #1 If_Shot = 2'b00;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (Busy) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_busy_timeout"}, 0, 1);
  endtask

  task automatic frame(input string name);
    bit ok;
    frame_clk = 1'b1;
    wait_busy(name);
    frame_clk = 1'b0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk); #1;
      if (!Busy) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_idle_timeout"}, 0, 1);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; frame_clk = 1'b0; If_Shot = 2'b00;
    Bullet_Damage = '0; Facing = '0; Player_X = '0; Player_Y = '0;
    RedBox_X = '0; RedBox_Y = '0; RedBox_Exist = '0;
    do_reset();

    // Reset state
    chk("rst_live", Tracer_Live, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_strobe", Hit_Strobe, 0);
    chk("rst_x0", Tracer_X[0], 0);

    // 1: reset lands on the scan cycle of a hitting pair (slot 0, zombie 9)
    Player_X[0] = 10'd200; Player_Y[0] = 10'd200; Facing[0] = 2'b00; Bullet_Damage[0] = 7'd3;
    RedBox_X[9] = 10'd200; RedBox_Y[9] = 10'd200; RedBox_Exist = 10'b10_0000_0000;
    shot(2'b01);
    frame_clk = 1'b1;
    wait_busy("t1");
    frame_clk = 1'b0;
    repeat (11) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    chk("t1_strobe", Hit_Strobe, 0);
    chk("t1_live", Tracer_Live, 0);
    chk("t1_busy", Busy, 0);
    Reset = 1'b0;
    RedBox_Exist = '0;
    repeat (2) @(posedge Clk); #1;

    // 2: spawn at player position, then one step right
    Player_X[0] = 10'd100; Player_Y[0] = 10'd200; Facing[0] = 2'b11; Bullet_Damage[0] = 7'd1;
    shot(2'b01);
    frame("t2a");
    chk("t2_live0", Tracer_Live[0], 1);
    chk("t2_x0_spawn", Tracer_X[0], 100);
    chk("t2_y0_spawn", Tracer_Y[0], 200);
    frame("t2b");
    chk("t2_x0_move", Tracer_X[0], 108);
    chk("t2_y0_move", Tracer_Y[0], 200);

    // 3: five P0 shots over five frames (up); P1 fires once (down)
    do_reset();
    Player_X[0] = 10'd100; Player_Y[0] = 10'd400; Facing[0] = 2'b00;
    Player_X[1] = 10'd500; Player_Y[1] = 10'd100; Facing[1] = 2'b01;
    shot(2'b11);
    frame("t3_1");
    chk("t3_x4_spawn", Tracer_X[4], 500);
    chk("t3_live_f1", Tracer_Live, 8'h11);
    for (int f = 2; f <= 4; f++) begin
      shot(2'b01);
      frame("t3_n");
    end
    push_drop(0);
    shot(2'b01);
    frame("t3_5");
    chk("t3_live_all", Tracer_Live, 8'h1F);
    chk("t3_y0", Tracer_Y[0], 368);
    chk("t3_y3", Tracer_Y[3], 392);
    chk("t3_y4", Tracer_Y[4], 132);

    // 4: right-moving tracer at the edge is freed, position held
    do_reset();
    Player_X[0] = 10'd632; Player_Y[0] = 10'd50; Facing[0] = 2'b11;
    shot(2'b01);
    frame("t4a");
    chk("t4_live_spawn", Tracer_Live[0], 1);
    frame("t4b");
    chk("t4_live_gone", Tracer_Live[0], 0);
    chk("t4_x_held", Tracer_X[0], 632);

    // 5: both players hit zombie 3; zombie 4 also in range but slots already dead
    do_reset();
    Player_X[0] = 10'd300; Player_Y[0] = 10'd300; Facing[0] = 2'b11; Bullet_Damage[0] = 7'd5;
    Player_X[1] = 10'd300; Player_Y[1] = 10'd300; Facing[1] = 2'b11; Bullet_Damage[1] = 7'd9;
    RedBox_X[3] = 10'd315; RedBox_Y[3] = 10'd300;
    RedBox_X[4] = 10'd318; RedBox_Y[4] = 10'd300;
    RedBox_Exist = 10'b00_0001_1000;
    shot(2'b11);
    frame("t5a");
    chk("t5_live_spawn", Tracer_Live, 8'h11);
    push_hit(3, 5);
    push_hit(3, 9);
    frame("t5b");
    chk("t5_live_freed", Tracer_Live, 0);
    chk("t5_x_held", Tracer_X[0], 308);

    // 6: same geometry, zombie 3 absent
    do_reset();
    RedBox_Exist = '0;
    shot(2'b01);
    frame("t6a");
    frame("t6b");
    chk("t6_live", Tracer_Live[0], 1);
    chk("t6_x", Tracer_X[0], 308);

    // Start low behaves as reset
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("start_low_live", Tracer_Live, 0);
    Start = 1'b1;
    repeat (3) @(posedge Clk); #1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
